blob_centroid_acc: RTL and testbench
====================================

// Module: blob_centroid_acc
// PURPOSE
//   Downstream of the background-subtraction stage. Snoops its write port
//   (writeEn/writeAddress/subtractedPixel) and thresholds each 8-bit difference pixel.
//   Per frame, accumulates foreground count, sum of x, sum of y and bounding box.
//   Publishes the frame result with a one-cycle strobe; the nav controller uses it for tracking.
// PARAMETERS
//   IMG_W    320   pixels per row; must be a multiple of 16 (20 words per row)
//   IMG_H    240   rows per frame (4800 words per frame)
//   THRESH   8'd40 a pixel is foreground iff value > THRESH (strict)
//   ADDR_W   13    word address width
// PORTS
//   clk          in   1    system clock, all logic on rising edge
//   rst_n        in   1    asynchronous active-low reset
//   writeEn      in   1    subtracted word valid this cycle
//   writeAddress in   13   word address of subtractedPixel, 0..IMG_W*IMG_H/16-1
//   subtractedPixel in 128 16 pixels; lane0=[127:120] is leftmost (x offset 0), lane15=[7:0]
//   currentFrame in   3    frame slot index, sampled with the address-0 word
//   res_valid    out  1    one-cycle strobe: result fields valid
//   res_frame    out  3    frame slot of the published result
//   fg_count     out  17   foreground pixel count
//   sum_x        out  32   sum of x of foreground pixels
//   sum_y        out  32   sum of y of foreground pixels
//   bbox_xmin/xmax out 9   bounding box columns
//   bbox_ymin/ymax out 8   bounding box rows
//   blob_found   out  1    fg_count != 0
//   seq_err      out  1    one-cycle strobe: frame aborted (address out of sequence)
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; accumulators, row/col counters 0.
//   Coordinates: internal word-column (0..IMG_W/16-1) and row counters; no divide.
//     x = col*16 + lane; y = row.
//   FSM: IDLE  -> ACCUM on writeEn && writeAddress==0. Latch currentFrame; clear accums.
//        ACCUM: every writeEn must carry exp_addr (previous+1).
//          Gaps (writeEn=0) are allowed with no limit.
//        ACCUM, writeEn, addr==last word -> DONE.
//        ACCUM, writeEn, addr!=exp_addr -> seq_err pulse, drop partial frame.
//          If that addr==0, restart ACCUM with this word; else go to IDLE.
//        DONE (1 cycle): drain pipeline, publish -> IDLE.
//   Pipeline:
//     S1 (registered): per-lane compare, popcount(0..16), lane-offset sum,
//       leftmost/rightmost fg lane.
//     S2: add into fg_count, sum_x += pop*col*16 + lanesum, sum_y += pop*row;
//       update bbox min/max.
//   Latency: res_valid is high exactly 3 clk after the edge that samples the last word.
//     Result outputs hold until the next publish.
//   Empty frame: fg_count=0, blob_found=0, bbox fields all 0, sums 0.
//   Overlap: an address-0 word arriving while DONE/publish is in flight starts the next
//     frame. The published result must not be corrupted (separate result registers).
//   writeAddress >= last word+1 while IDLE: ignored. While ACCUM: seq_err.
//   Reset asserted mid-frame: immediate clear. No res_valid or seq_err for the lost frame.
//   Widths: sums sized for the 320x240 worst case (< 2^25); no saturation needed.
// TESTING
//   1 All-zero frame of 4800 words, frame 3
//     -> res_valid once, res_frame=3, fg_count=0, blob_found=0.
//   2 Every word = 128'h01ff45008900cd0001ff45008900cd00 (8 fg/word: lanes 1,2,4,6,9,10,12,14)
//     -> fg_count=38400, bbox x 1..318, y 0..239.
//   3 Single word at addr 21 = 128'hff<<120, rest 0
//     -> fg_count=1, sum_x=16, sum_y=1, bbox (16,1)-(16,1).
//   4 Pixel exactly 8'd40 everywhere -> fg_count=0 (strict compare).
//     8'd41 -> fg_count=76800.
//   5 Frame aborts at addr 100 with a write to addr 200 -> seq_err pulse, no res_valid.
//     A following full frame reports normally.
//   6 rst_n low for 2 clk at word 2000
//     -> outputs 0, no strobe. A subsequent full frame of test-3 data -> fg_count=1.
//     Random writeEn gaps still give identical results.

Source files
------------

// File: rtl/blob_centroid_acc.sv
// blob_centroid_acc: thresholds snooped subtracted-pixel words and accumulates per-frame foreground count, centroid sums and bounding box.
module blob_centroid_acc #(
  parameter int          IMG_W  = 320,
  parameter int          IMG_H  = 240,
  parameter logic [7:0]  THRESH = 8'd40,
  parameter int          ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [127:0]      subtractedPixel,
  input  logic [2:0]        currentFrame,
  output logic              res_valid,
  output logic [2:0]        res_frame,
  output logic [16:0]       fg_count,
  output logic [31:0]       sum_x,
  output logic [31:0]       sum_y,
  output logic [8:0]        bbox_xmin,
  output logic [8:0]        bbox_xmax,
  output logic [7:0]        bbox_ymin,
  output logic [7:0]        bbox_ymax,
  output logic              blob_found,
  output logic              seq_err
);
  localparam int COLS = IMG_W / 16;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * IMG_H - 1);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] exp_addr;
  logic [CW-1:0] col, wcol, col_nx;
  logic [RW-1:0] row, wrow, row_nx;
  logic [2:0] frame;
  logic start, hit, take, is_last, seq_nx;
  always_comb begin
    start    = writeEn && writeAddress == '0;
    hit      = writeEn && state == ACCUM && writeAddress == exp_addr;
    seq_nx   = writeEn && state == ACCUM && writeAddress != exp_addr;
    take     = start || hit;
    is_last  = writeAddress == LAST;
    state_nx = take ? (is_last ? DONE : ACCUM) : seq_nx ? IDLE : state == DONE ? IDLE : state;
    wcol     = start ? '0 : col;
    wrow     = start ? '0 : row;
    col_nx   = wcol == CW'(COLS - 1) ? '0 : wcol + 1'b1;
    row_nx   = wcol == CW'(COLS - 1) ? wrow + 1'b1 : wrow;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      exp_addr <= '0;
      col      <= '0;
      row      <= '0;
      frame    <= '0;
      seq_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      seq_err <= seq_nx;
      if (take) begin
        exp_addr <= writeAddress + 1'b1;
        col      <= col_nx;
        row      <= row_nx;
      end
      if (start) frame <= currentFrame;
    end
  logic [4:0] pop;
  logic [6:0] lsum;
  logic [3:0] lmin, lmax;
  always_comb begin
    pop  = '0;
    lsum = '0;
    lmin = '0;
    lmax = '0;
    for (int i = 0; i < 16; i++)
      if (subtractedPixel[127-8*i -: 8] > THRESH) begin
        if (pop == '0) lmin = 4'(i);
        lmax = 4'(i);
        pop  = pop + 1'b1;
        lsum = lsum + 7'(i);
      end
  end
  logic v1, first1, last1;
  logic [4:0] pop1;
  logic [6:0] lsum1;
  logic [3:0] lmin1, lmax1;
  logic [CW-1:0] col1;
  logic [RW-1:0] row1;
  logic [2:0] frame1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      pop1   <= '0;
      lsum1  <= '0;
      lmin1  <= '0;
      lmax1  <= '0;
      col1   <= '0;
      row1   <= '0;
      frame1 <= '0;
    end else begin
      v1 <= take;
      if (take) begin
        first1 <= start;
        last1  <= is_last;
        pop1   <= pop;
        lsum1  <= lsum;
        lmin1  <= lmin;
        lmax1  <= lmax;
        col1   <= wcol;
        row1   <= wrow;
        frame1 <= start ? currentFrame : frame;
      end
    end
  // first1 restarts the accumulators in place, so an aborted partial frame never needs an explicit flush
  logic [16:0] acc_cnt, base_cnt;
  logic [31:0] acc_sx, acc_sy, base_sx, base_sy;
  logic [8:0] acc_xmin, acc_xmax, xlo, xhi;
  logic [7:0] acc_ymin, acc_ymax;
  logic [2:0] acc_frame;
  logic acc_last;
  always_comb begin
    base_cnt = first1 ? '0 : acc_cnt;
    base_sx  = first1 ? '0 : acc_sx;
    base_sy  = first1 ? '0 : acc_sy;
    xlo      = 9'(col1) * 9'd16 + 9'(lmin1);
    xhi      = 9'(col1) * 9'd16 + 9'(lmax1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_cnt   <= '0;
      acc_sx    <= '0;
      acc_sy    <= '0;
      acc_xmin  <= '0;
      acc_xmax  <= '0;
      acc_ymin  <= '0;
      acc_ymax  <= '0;
      acc_frame <= '0;
      acc_last  <= 1'b0;
    end else begin
      acc_last <= v1 && last1;
      if (v1) begin
        acc_cnt   <= base_cnt + 17'(pop1);
        acc_sx    <= base_sx + 32'(pop1) * 32'(col1) * 32'd16 + 32'(lsum1);
        acc_sy    <= base_sy + 32'(pop1) * 32'(row1);
        acc_frame <= frame1;
        if (pop1 != '0) begin
          if (base_cnt == '0 || xlo < acc_xmin) acc_xmin <= xlo;
          if (base_cnt == '0 || xhi > acc_xmax) acc_xmax <= xhi;
          if (base_cnt == '0) acc_ymin <= 8'(row1);
          acc_ymax <= 8'(row1);
        end
      end
    end
  // snapshot stage: the next frame may overwrite the accumulators on the same edge the result is captured
  logic stg_v;
  logic [16:0] stg_cnt;
  logic [31:0] stg_sx, stg_sy;
  logic [8:0] stg_xmin, stg_xmax;
  logic [7:0] stg_ymin, stg_ymax;
  logic [2:0] stg_frame;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg_v     <= 1'b0;
      stg_cnt   <= '0;
      stg_sx    <= '0;
      stg_sy    <= '0;
      stg_xmin  <= '0;
      stg_xmax  <= '0;
      stg_ymin  <= '0;
      stg_ymax  <= '0;
      stg_frame <= '0;
    end else begin
      stg_v <= acc_last;
      if (acc_last) begin
        stg_cnt   <= acc_cnt;
        stg_sx    <= acc_sx;
        stg_sy    <= acc_sy;
        stg_xmin  <= acc_cnt == '0 ? '0 : acc_xmin;
        stg_xmax  <= acc_cnt == '0 ? '0 : acc_xmax;
        stg_ymin  <= acc_cnt == '0 ? '0 : acc_ymin;
        stg_ymax  <= acc_cnt == '0 ? '0 : acc_ymax;
        stg_frame <= acc_frame;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_frame  <= '0;
      fg_count   <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
      blob_found <= 1'b0;
    end else begin
      res_valid <= stg_v;
      if (stg_v) begin
        res_frame  <= stg_frame;
        fg_count   <= stg_cnt;
        sum_x      <= stg_sx;
        sum_y      <= stg_sy;
        bbox_xmin  <= stg_xmin;
        bbox_xmax  <= stg_xmax;
        bbox_ymin  <= stg_ymin;
        bbox_ymax  <= stg_ymax;
        blob_found <= stg_cnt != '0;
      end
    end
endmodule

// File: tb/tb_blob_centroid_acc.sv
// tb_blob_centroid_acc: table-driven frames with hand-computed results plus abort, restart and mid-frame reset sequences.
module tb_blob_centroid_acc;
  logic clk = 1'b0, rst_n = 1'b0, writeEn = 1'b0;
  logic [12:0] writeAddress = '0;
  logic [127:0] subtractedPixel = '0;
  logic [2:0] currentFrame = '0;
  logic res_valid, blob_found, seq_err;
  logic [2:0] res_frame;
  logic [16:0] fg_count;
  logic [31:0] sum_x, sum_y;
  logic [8:0] bbox_xmin, bbox_xmax;
  logic [7:0] bbox_ymin, bbox_ymax;
  blob_centroid_acc dut (
    .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeAddress(writeAddress),
    .subtractedPixel(subtractedPixel), .currentFrame(currentFrame),
    .res_valid(res_valid), .res_frame(res_frame), .fg_count(fg_count),
    .sum_x(sum_x), .sum_y(sum_y), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .blob_found(blob_found), .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int kind;
    logic [2:0] frame;
    int cnt, sx, sy, xmin, xmax, ymin, ymax, cyc;
  } vec_t;
  vec_t tbl[5];
  vec_t expq[$];
  vec_t mon_e, v;
  int cmp = 0, bad = 0, nerr = 0;
  task automatic chk(input string name, input longint act, input longint req);
    cmp++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask
  function automatic logic [127:0] word(input int kind, input int a);
    logic [127:0] r;
    r = '0;
    case (kind)
      1: r = 128'h01ff45008900cd0001ff45008900cd00;
      2: if (a == 21) r = {8'hff, 120'h0};
      3: r = {16{8'd40}};
      4: r = {16{8'd41}};
      default: r = '0;
    endcase
    return r;
  endfunction
  task automatic send_word(input int a, input logic [127:0] d, input logic [2:0] f);
    @(negedge clk);
    writeEn = 1'b1;
    writeAddress = 13'(a);
    subtractedPixel = d;
    currentFrame = f;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      writeEn = 1'b0;
    end
  endtask
  task automatic send_frame(input vec_t f, input int upto, input int gap);
    for (int a = 0; a < upto; a++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) idle(1);
      send_word(a, word(f.kind, a), f.frame);
    end
    if (upto == 4800) begin
      f.cyc = cyc + 4;
      expq.push_back(f);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_frame"}, res_frame, 0);
    chk({tag, "_fg_count"}, fg_count, 0);
    chk({tag, "_sum_x"}, sum_x, 0);
    chk({tag, "_sum_y"}, sum_y, 0);
    chk({tag, "_bbox"}, {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
    chk({tag, "_blob_found"}, blob_found, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
  endtask
  always @(negedge clk) begin
    if (seq_err) nerr++;
    if (res_valid) begin
      if (expq.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_res_valid: strobe at cycle %0d, none expected", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("latency", cyc, mon_e.cyc);
        chk("res_frame", res_frame, mon_e.frame);
        chk("fg_count", fg_count, mon_e.cnt);
        chk("sum_x", sum_x, mon_e.sx);
        chk("sum_y", sum_y, mon_e.sy);
        chk("bbox_xmin", bbox_xmin, mon_e.xmin);
        chk("bbox_xmax", bbox_xmax, mon_e.xmax);
        chk("bbox_ymin", bbox_ymin, mon_e.ymin);
        chk("bbox_ymax", bbox_ymax, mon_e.ymax);
        chk("blob_found", blob_found, mon_e.cnt != 0);
      end
    end
  end
  initial begin
    tbl[0] = '{0, 3'd3, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 3'd1, 38400, 6115200, 4588800, 1, 318, 0, 239, 0};
    tbl[2] = '{2, 3'd2, 1, 16, 1, 16, 16, 1, 1, 0};
    tbl[3] = '{3, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{4, 3'd5, 76800, 12249600, 9177600, 0, 319, 0, 239, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset");
    for (int i = 0; i < 5; i++) send_frame(tbl[i], 4800, 0);
    idle(10);
    chk("results_after_table", expq.size(), 0);
    send_word(4800, '1, 3'd0);
    send_word(8191, '1, 3'd0);
    idle(5);
    chk("seq_err_idle_ignore", nerr, 0);
    v = tbl[2];
    v.frame = 3'd6;
    send_frame(v, 101, 0);
    send_word(200, '0, 3'd6);
    idle(5);
    chk("seq_err_abort", nerr, 1);
    v = tbl[4];
    v.frame = 3'd0;
    send_frame(v, 4800, 0);
    idle(10);
    chk("results_after_abort", expq.size(), 0);
    v = tbl[2];
    v.frame = 3'd6;
    send_frame(v, 31, 0);
    send_frame(v, 4800, 0);
    idle(10);
    chk("seq_err_restart", nerr, 2);
    chk("results_after_restart", expq.size(), 0);
    v.frame = 3'd7;
    send_frame(v, 2001, 0);
    @(negedge clk);
    rst_n = 1'b0;
    writeEn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_zero("midrst");
    send_frame(v, 4800, 30);
    idle(10);
    chk("results_final", expq.size(), 0);
    chk("seq_err_final", nerr, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
